// File: rtl/rx_fsm_ctrl_if.sv
// Control bundle between the UART receive FSM and its counter, sampler and checkers.
// The master side is the FSM; the slave side is the surrounding datapath.
interface rx_fsm_ctrl_if;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic [4:0] edge_cnt;
    logic [2:0] bit_cnt;
    logic       bit_done;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       edge_count_enable;
    logic       bit_count_enable;
    logic       data_samp_en;
    logic       deser_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       PAR_ERR;
    logic       STP_ERR;

    modport master (
        input  RX_IN, PAR_EN, Prescale, edge_cnt, bit_cnt, bit_done,
        input  strt_glitch, par_err, stp_err,
        output edge_count_enable, bit_count_enable, data_samp_en,
        output deser_en, strt_chk_en, par_chk_en, stp_chk_en,
        output data_valid, PAR_ERR, STP_ERR
    );

    modport slave (
        output RX_IN, PAR_EN, Prescale, edge_cnt, bit_cnt, bit_done,
        output strt_glitch, par_err, stp_err,
        input  edge_count_enable, bit_count_enable, data_samp_en,
        input  deser_en, strt_chk_en, par_chk_en, stp_chk_en,
        input  data_valid, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/rx_fsm_ctrl.sv
// UART receive control FSM: sequences start/data/parity/stop bits, issues mid-bit
// strobes to sampler and checkers, and reports frame status.
module rx_fsm_ctrl (
    input  logic            CLK,
    input  logic            RST,
    rx_fsm_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic   par_flag_q, par_flag_d;
    logic   data_valid_q, data_valid_d;
    logic   par_err_q, par_err_d;
    logic   stp_err_q, stp_err_d;

    logic   edge_count_en, bit_count_en, samp_en;
    logic   deser, strt_chk, par_chk, stp_chk;
    logic   strobe;

    // Mid-bit sample point, compared at 6 bits so Prescale=32 cannot overflow.
    assign strobe = ({1'b0, bus.edge_cnt} == ((bus.Prescale >> 1) + 6'd2));

    always_comb begin
        state_d       = state_q;
        edge_count_en = 1'b0;
        bit_count_en  = 1'b0;
        samp_en       = 1'b0;
        deser         = 1'b0;
        strt_chk      = 1'b0;
        par_chk       = 1'b0;
        stp_chk       = 1'b0;
        case (state_q)
            StIdle: begin
                if (!bus.RX_IN) state_d = StStart;
            end
            StStart: begin
                edge_count_en = 1'b1;
                samp_en       = 1'b1;
                strt_chk      = strobe;
                if (bus.bit_done) state_d = bus.strt_glitch ? StIdle : StData;
            end
            StData: begin
                edge_count_en = 1'b1;
                bit_count_en  = 1'b1;
                samp_en       = 1'b1;
                deser         = strobe;
                if (bus.bit_done && (bus.bit_cnt == 3'd7)) begin
                    state_d = bus.PAR_EN ? StParity : StStop;
                end
            end
            StParity: begin
                edge_count_en = 1'b1;
                samp_en       = 1'b1;
                par_chk       = strobe;
                if (bus.bit_done) state_d = StStop;
            end
            StStop: begin
                edge_count_en = 1'b1;
                samp_en       = 1'b1;
                stp_chk       = strobe;
                if (bus.bit_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        par_flag_d   = par_flag_q;
        data_valid_d = 1'b0;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;
        if ((state_q == StIdle) && (state_d == StStart)) begin
            par_flag_d = 1'b0;
        end else if ((state_q == StParity) && bus.bit_done) begin
            par_flag_d = bus.par_err;
        end
        // Status only updates on a completed frame; a start glitch leaves it untouched.
        if ((state_q == StStop) && bus.bit_done) begin
            data_valid_d = !par_flag_q && !bus.stp_err;
            par_err_d    = par_flag_q;
            stp_err_d    = bus.stp_err;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= StIdle;
            par_flag_q   <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            par_flag_q   <= par_flag_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign bus.edge_count_enable = edge_count_en;
    assign bus.bit_count_enable  = bit_count_en;
    assign bus.data_samp_en      = samp_en;
    assign bus.deser_en          = deser;
    assign bus.strt_chk_en       = strt_chk;
    assign bus.par_chk_en        = par_chk;
    assign bus.stp_chk_en        = stp_chk;
    assign bus.data_valid        = data_valid_q;
    assign bus.PAR_ERR           = par_err_q;
    assign bus.STP_ERR           = stp_err_q;

endmodule

// File: tb/tb_rx_fsm_ctrl.sv
// Directed bench for rx_fsm_ctrl with a behavioural edge/bit counter and
// checker-flag driver around the FSM.
module tb_rx_fsm_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    rx_fsm_ctrl_if bus ();

    rx_fsm_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Edge/bit counter model
    logic [4:0] ec_q;
    logic [2:0] bc_q;
    logic       bd;

    assign bd           = bus.edge_count_enable && ({1'b0, ec_q} == (bus.Prescale - 6'd1));
    assign bus.edge_cnt = ec_q;
    assign bus.bit_cnt  = bc_q;
    assign bus.bit_done = bd;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ec_q <= '0;
            bc_q <= '0;
        end else begin
            if (!bus.edge_count_enable || bd) ec_q <= '0;
            else                              ec_q <= ec_q + 5'd1;
            if (!bus.bit_count_enable) bc_q <= '0;
            else if (bd)               bc_q <= bc_q + 3'd1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ctrl_vec();
        return {bus.edge_count_enable, bus.bit_count_enable, bus.data_samp_en, bus.deser_en,
                bus.strt_chk_en, bus.par_chk_en, bus.stp_chk_en, bus.data_valid,
                bus.PAR_ERR, bus.STP_ERR};
    endfunction

    typedef struct {
        int lat;
        int start_cyc;
        int n_strt;
        int n_deser;
        int n_par;
        int n_stp;
        int n_dv;
        int bad_strobe;
        int timeout;
    } res_t;

    // Launches a frame at the current negedge and returns at the first idle negedge.
    task automatic run_frame(input logic [5:0] ps, input logic pe, input logic [7:0] data,
                             input logic glitch, input logic perr, input logic serr,
                             output res_t r);
        logic seen, seen_data, prev_bd;
        int   strobe_pt, n_str;
        r = '{default: 0};
        seen = 1'b0; seen_data = 1'b0; prev_bd = 1'b0;
        strobe_pt = int'(ps) / 2 + 2;
        bus.Prescale = ps;
        bus.PAR_EN   = pe;
        bus.RX_IN    = 1'b0;
        r.timeout    = 1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge CLK);
            if (!seen) r.lat++;
            if (bus.data_valid) r.n_dv++;
            if (prev_bd) begin
                bus.strt_glitch = 1'b0;
                bus.par_err     = 1'b0;
                bus.stp_err     = 1'b0;
            end
            if (seen && !bus.edge_count_enable) begin
                r.timeout = 0;
                break;
            end
            if (bus.edge_count_enable) seen = 1'b1;
            if (bus.bit_count_enable) seen_data = 1'b1;
            if (bus.edge_count_enable && !bus.bit_count_enable && !seen_data) r.start_cyc++;
            n_str = int'(bus.strt_chk_en) + int'(bus.deser_en) + int'(bus.par_chk_en)
                  + int'(bus.stp_chk_en);
            if (n_str > 1 || (n_str == 1 && int'(ec_q) != strobe_pt)) r.bad_strobe++;
            if (bus.bit_count_enable)   bus.RX_IN = data[bc_q];
            else if (seen_data)         bus.RX_IN = 1'b1;
            if (bus.strt_chk_en) begin
                r.n_strt++;
                bus.strt_glitch = glitch;
                if (glitch) bus.RX_IN = 1'b1;
            end
            if (bus.deser_en) r.n_deser++;
            if (bus.par_chk_en) begin
                r.n_par++;
                bus.par_err = perr;
            end
            if (bus.stp_chk_en) begin
                r.n_stp++;
                bus.stp_err = serr;
            end
            prev_bd = bd;
        end
    endtask

    res_t r;
    logic found;
    int   n_dv_after, n_act_after;

    initial begin
        bus.RX_IN       = 1'b1;
        bus.PAR_EN      = 1'b0;
        bus.Prescale    = 6'd8;
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stp_err     = 1'b0;
        #3;
        check_eq("reset_outputs", 32'(ctrl_vec()), 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check_eq("idle_no_enable", 32'(bus.edge_count_enable), 32'd0);

        // A: Prescale 8, no parity, 0x55, good stop
        run_frame(6'd8, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, r);
        check_eq("A_timeout", r.timeout, 0);
        check_eq("A_lat", r.lat, 1);
        check_eq("A_start_cycles", r.start_cyc, 8);
        check_eq("A_strt_chk", r.n_strt, 1);
        check_eq("A_deser", r.n_deser, 8);
        check_eq("A_par_chk", r.n_par, 0);
        check_eq("A_stp_chk", r.n_stp, 1);
        check_eq("A_strobe_pos", r.bad_strobe, 0);
        check_eq("A_dv", r.n_dv, 1);
        check_eq("A_par_err", 32'(bus.PAR_ERR), 32'd0);
        check_eq("A_stp_err", 32'(bus.STP_ERR), 32'd0);
        @(negedge CLK);
        check_eq("A_dv_one_cycle", 32'(bus.data_valid), 32'd0);
        repeat (2) @(negedge CLK);

        // B: Prescale 16, parity with par_err
        run_frame(6'd16, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, r);
        check_eq("B_timeout", r.timeout, 0);
        check_eq("B_deser", r.n_deser, 8);
        check_eq("B_par_chk", r.n_par, 1);
        check_eq("B_stp_chk", r.n_stp, 1);
        check_eq("B_strobe_pos", r.bad_strobe, 0);
        check_eq("B_dv", r.n_dv, 0);
        check_eq("B_par_err", 32'(bus.PAR_ERR), 32'd1);
        check_eq("B_stp_err", 32'(bus.STP_ERR), 32'd0);
        repeat (2) @(negedge CLK);

        // C: Prescale 32, start glitch
        run_frame(6'd32, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, r);
        check_eq("C_timeout", r.timeout, 0);
        check_eq("C_start_cycles", r.start_cyc, 32);
        check_eq("C_strt_chk", r.n_strt, 1);
        check_eq("C_strobe_pos", r.bad_strobe, 0);
        check_eq("C_deser", r.n_deser, 0);
        check_eq("C_stp_chk", r.n_stp, 0);
        check_eq("C_dv", r.n_dv, 0);
        check_eq("C_par_err_held", 32'(bus.PAR_ERR), 32'd1);
        check_eq("C_stp_err_held", 32'(bus.STP_ERR), 32'd0);
        repeat (2) @(negedge CLK);

        // D: stop error
        run_frame(6'd8, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, r);
        check_eq("D_dv", r.n_dv, 0);
        check_eq("D_stp_err", 32'(bus.STP_ERR), 32'd1);
        check_eq("D_par_err", 32'(bus.PAR_ERR), 32'd0);
        repeat (2) @(negedge CLK);

        // E then F back-to-back
        run_frame(6'd8, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, r);
        check_eq("E_dv", r.n_dv, 1);
        check_eq("E_stp_err_clear", 32'(bus.STP_ERR), 32'd0);
        run_frame(6'd8, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, r);
        check_eq("F_timeout", r.timeout, 0);
        check_eq("F_lat", r.lat, 1);
        check_eq("F_start_cycles", r.start_cyc, 8);
        check_eq("F_dv", r.n_dv, 1);
        repeat (2) @(negedge CLK);

        // G: both errors, so reset has status to clear
        run_frame(6'd16, 1'b1, 8'h81, 1'b0, 1'b1, 1'b1, r);
        check_eq("G_dv", r.n_dv, 0);
        check_eq("G_errs", 32'({bus.PAR_ERR, bus.STP_ERR}), 32'h3);
        repeat (2) @(negedge CLK);

        // Reset in DATA at bit_cnt 4
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        found        = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge CLK);
            bus.RX_IN = 1'b1;
            if (bus.bit_count_enable && bc_q == 3'd4) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("R_reached_bit4", 32'(found), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check_eq("R_outputs_zero", 32'(ctrl_vec()), 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        n_dv_after  = 0;
        n_act_after = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge CLK);
            if (bus.data_valid) n_dv_after++;
            if (bus.edge_count_enable) n_act_after++;
        end
        check_eq("R_no_dv", n_dv_after, 0);
        check_eq("R_stays_idle", n_act_after, 0);

        // H: first frame after reset
        run_frame(6'd16, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, r);
        check_eq("H_lat", r.lat, 1);
        check_eq("H_par_chk", r.n_par, 1);
        check_eq("H_dv", r.n_dv, 1);
        check_eq("H_errs", 32'({bus.PAR_ERR, bus.STP_ERR}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
